// File: rtl/spi_i2s_pkg.sv
// rtl/spi_i2s_pkg.sv - shared FSM type and register map for the SPI/I2S APB master
package spi_i2s_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDAT   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_RHOLD  = 3'd4
    } apb_state_e;

    localparam logic [7:0] REG_CR1  = 8'h00;
    localparam logic [7:0] REG_CR2  = 8'h04;
    localparam logic [7:0] REG_SR   = 8'h08;
    localparam logic [7:0] REG_DR   = 8'h0C;
    localparam logic [7:0] REG_DREG = 8'h10;
    localparam logic [7:0] REG_CFGR = 8'h1C;
    localparam logic [7:0] REG_PR   = 8'h20;
    localparam logic [7:0] REG_HINT = 8'h24;

    // byte step between consecutive words of an incrementing burst
    localparam int unsigned ADDR_INCR = 4;

endpackage

// File: rtl/spi_i2s_apb_master.sv
// rtl/spi_i2s_apb_master.sv - command-driven APB initiator with burst, wait-state and timeout handling
module spi_i2s_apb_master
    import spi_i2s_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_incr,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    // counter wide enough to hold TIMEOUT-1; one bit minimum so TIMEOUT=0 still elaborates
    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_e        state_q, state_d;
    logic              en_q;
    logic              write_q, write_d;
    logic              incr_q, incr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              done_q, done_d;
    logic              fin;
    logic              nxt;
    logic              last_beat;

    assign last_beat   = (cnt_q == '0);
    // en_q keeps cmd_ready low while reset is held, then stays high forever
    assign cmd_ready   = en_q && (state_q == ST_IDLE);
    assign wdata_ready = (state_q == ST_WDAT);
    assign rdata_valid = (state_q == ST_RHOLD);
    assign psel        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign penable     = (state_q == ST_ACCESS);
    assign busy        = (state_q != ST_IDLE);
    assign pwrite      = write_q;
    assign paddr       = addr_q;
    assign pwdata      = pwdata_q;
    assign rdata       = rdata_q;
    assign done        = done_q;
    assign err         = done_q && err_q;

    // next-state logic; fin/nxt fold the shared finish and continue actions
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        incr_d   = incr_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        to_d     = '0;
        done_d   = 1'b0;
        fin      = 1'b0;
        nxt      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    write_d = cmd_write;
                    incr_d  = cmd_incr;
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    err_d   = 1'b0;
                    state_d = cmd_write ? ST_WDAT : ST_SETUP;
                end
            end
            ST_WDAT: begin
                if (wdata_valid) begin
                    pwdata_d = wdata;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    if (!write_q) begin
                        // an erroring read is still handed to the consumer before aborting
                        rdata_d = prdata;
                        state_d = ST_RHOLD;
                        if (pslverr) begin
                            err_d = 1'b1;
                        end
                    end else if (pslverr) begin
                        err_d = 1'b1;
                        fin   = 1'b1;
                    end else if (last_beat) begin
                        fin = 1'b1;
                    end else begin
                        nxt = 1'b1;
                    end
                end else if ((TIMEOUT != 0) && (to_q == TO_LAST)) begin
                    err_d = 1'b1;
                    fin   = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            ST_RHOLD: begin
                if (rdata_ready) begin
                    if (err_q || last_beat) begin
                        fin = 1'b1;
                    end else begin
                        nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (fin) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
        end
        if (nxt) begin
            cnt_d   = cnt_q - LEN_W'(1);
            addr_d  = incr_q ? addr_q + ADDR_W'(ADDR_INCR) : addr_q;
            state_d = write_q ? ST_WDAT : ST_SETUP;
        end
    end

    // state and datapath registers, all cleared by reset
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            en_q     <= 1'b0;
            write_q  <= 1'b0;
            incr_q   <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            to_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= 1'b1;
            write_q  <= write_d;
            incr_q   <= incr_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            to_q     <= to_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_i2s_apb_master.sv
// tb/tb_spi_i2s_apb_master.sv - directed self-checking bench for spi_i2s_apb_master
module tb_spi_i2s_apb_master;
    import spi_i2s_pkg::*;

    logic        pclk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_incr;
    logic [7:0]  cmd_addr;
    logic [3:0]  cmd_len;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid, rdata_ready;
    logic [31:0] rdata;
    logic        done, err, busy;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;

    spi_i2s_apb_master #(.ADDR_W(8), .DATA_W(32), .LEN_W(4), .TIMEOUT(16)) dut (
        .pclk(pclk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_incr(cmd_incr),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .done(done), .err(err), .busy(busy),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_checks, n_pass;

    // per-run stimulus knobs
    logic [31:0] wbeats [16];
    logic [31:0] rresp [16];
    int          wait_cyc [16];
    int          err_beat, stall_beat, stall_cyc;

    // per-run observations
    logic [7:0]  obs_addr [32];
    logic        obs_wr [32];
    logic [31:0] obs_wd [32];
    int          obs_acc [32];
    logic [31:0] obs_rd [32];
    int n_xfer, n_setup, n_rd, n_wd, stable_bad, gap_bad, stall_bad;
    int accept_cyc, wd_hs_cyc, first_rv_cyc, done_cyc, done_cnt;
    logic err_at_done, ready_at_done, busy_at_done;

    task automatic clear_knobs();
        for (int i = 0; i < 16; i++) begin
            wbeats[i] = 32'h0; rresp[i] = 32'h0; wait_cyc[i] = 0;
        end
        err_beat = -1; stall_beat = -1; stall_cyc = 0;
    endtask

    // issues one command and plays host, write source, read sink and APB slave cycle by cycle
    task automatic run_burst(input bit wr, input logic [7:0] addr, input logic [3:0] len,
                             input bit inc, input int budget);
        logic [7:0]  h_addr;
        logic        h_wr;
        logic [31:0] h_wd, held_rd;
        int acc_cnt, stall_left;
        bit prev_pen, prev_stall;
        for (int i = 0; i < 32; i++) begin
            obs_addr[i] = 'x; obs_wr[i] = 1'bx; obs_wd[i] = 'x; obs_acc[i] = -1; obs_rd[i] = 'x;
        end
        n_xfer = 0; n_setup = 0; n_rd = 0; n_wd = 0; stable_bad = 0; gap_bad = 0; stall_bad = 0;
        accept_cyc = -1; wd_hs_cyc = -1; first_rv_cyc = -1; done_cyc = -1; done_cnt = 0;
        err_at_done = 1'bx; ready_at_done = 1'bx; busy_at_done = 1'bx;
        h_addr = '0; h_wr = 1'b0; h_wd = '0; held_rd = '0;
        acc_cnt = 0; stall_left = stall_cyc; prev_pen = 1'b0; prev_stall = 1'b0;
        @(negedge pclk);
        cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_incr = inc;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (prev_pen && !penable) begin
                if (n_xfer < 32) obs_acc[n_xfer] = acc_cnt;
                n_xfer++;
            end
            if (done) begin
                done_cnt++; done_cyc = cyc;
                err_at_done = err; ready_at_done = cmd_ready; busy_at_done = busy;
                break;
            end
            cmd_valid = (accept_cyc < 0);
            if (cmd_valid && cmd_ready) accept_cyc = cyc;
            wdata_valid = wdata_ready;
            wdata = wbeats[n_wd % 16];
            if (wdata_ready) begin
                wd_hs_cyc = cyc; n_wd++;
            end
            // junk on pslverr/prdata wherever the master must not sample them
            pready = 1'b0; pslverr = 1'b1; prdata = 32'hDEAD_BEEF;
            if (psel && !penable) begin
                if (n_setup < 32) begin
                    obs_addr[n_setup] = paddr; obs_wr[n_setup] = pwrite; obs_wd[n_setup] = pwdata;
                end
                n_setup++;
                h_addr = paddr; h_wr = pwrite; h_wd = pwdata; acc_cnt = 0;
                if (prev_pen) gap_bad++;
            end else if (psel && penable) begin
                if (paddr !== h_addr || pwrite !== h_wr || (h_wr && pwdata !== h_wd)) stable_bad++;
                acc_cnt++;
                if (acc_cnt > wait_cyc[n_xfer % 16]) begin
                    pready = 1'b1;
                    pslverr = (n_xfer == err_beat);
                    prdata = rresp[n_xfer % 16];
                end
            end
            rdata_ready = 1'b1;
            if (rdata_valid) begin
                if (first_rv_cyc < 0) first_rv_cyc = cyc;
                if (n_rd == stall_beat && stall_left > 0) begin
                    rdata_ready = 1'b0; stall_left--;
                    if (psel || (prev_stall && rdata !== held_rd)) stall_bad++;
                    held_rd = rdata; prev_stall = 1'b1;
                end else begin
                    if (prev_stall && rdata !== held_rd) stall_bad++;
                    prev_stall = 1'b0;
                    if (n_rd < 32) obs_rd[n_rd] = rdata;
                    n_rd++;
                end
            end
            prev_pen = penable;
            @(negedge pclk);
        end
        cmd_valid = 1'b0; wdata_valid = 1'b0; pready = 1'b0; pslverr = 1'b0; rdata_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge pclk);
        n_checks++; if ({psel, penable, pwrite, cmd_ready, wdata_ready, rdata_valid, done, err, busy} !== 9'b0)
            $display("FAIL reset_ctrl got %b want 000000000", {psel, penable, pwrite, cmd_ready, wdata_ready, rdata_valid, done, err, busy}); else n_pass++;
        n_checks++; if ({paddr, pwdata, rdata} !== 72'h0)
            $display("FAIL reset_data got %h want 0", {paddr, pwdata, rdata}); else n_pass++;
        rst_n = 1'b1;
        @(negedge pclk);
        n_checks++; if ({cmd_ready, busy} !== 2'b10)
            $display("FAIL reset_idle got %b want 10", {cmd_ready, busy}); else n_pass++;
    endtask

    task automatic test_single_write();
        clear_knobs();
        wbeats[0] = 32'h0000_1044;
        run_burst(1'b1, REG_CR1, 4'd0, 1'b0, 20);
        n_checks++; if (done_cnt !== 1) $display("FAIL sw_done got %0d want 1", done_cnt); else n_pass++;
        n_checks++; if ({n_setup, n_xfer} !== {32'd1, 32'd1}) $display("FAIL sw_xfers got %0d/%0d want 1/1", n_setup, n_xfer); else n_pass++;
        n_checks++; if ({obs_addr[0], obs_wr[0], obs_wd[0]} !== {8'h00, 1'b1, 32'h0000_1044})
            $display("FAIL sw_apb got %h %b %h want 00 1 00001044", obs_addr[0], obs_wr[0], obs_wd[0]); else n_pass++;
        n_checks++; if (done_cyc - wd_hs_cyc !== 3) $display("FAIL sw_latency got %0d want 3", done_cyc - wd_hs_cyc); else n_pass++;
        n_checks++; if ({err_at_done, ready_at_done, busy_at_done} !== 3'b010)
            $display("FAIL sw_done_flags got %b want 010", {err_at_done, ready_at_done, busy_at_done}); else n_pass++;
        n_checks++; if (obs_acc[0] !== 1) $display("FAIL sw_access got %0d want 1", obs_acc[0]); else n_pass++;
    endtask

    task automatic test_read_fixed();
        clear_knobs();
        rresp[0] = 32'h11; rresp[1] = 32'h22; rresp[2] = 32'h33; rresp[3] = 32'h44;
        run_burst(1'b0, REG_DR, 4'd3, 1'b0, 40);
        n_checks++; if (n_xfer !== 4) $display("FAIL rf_xfers got %0d want 4", n_xfer); else n_pass++;
        n_checks++; if ({obs_addr[0], obs_addr[1], obs_addr[2], obs_addr[3]} !== 32'h0C0C_0C0C)
            $display("FAIL rf_addr got %h %h %h %h want 0c x4", obs_addr[0], obs_addr[1], obs_addr[2], obs_addr[3]); else n_pass++;
        n_checks++; if ({obs_rd[0], obs_rd[1], obs_rd[2], obs_rd[3]} !== {32'h11, 32'h22, 32'h33, 32'h44})
            $display("FAIL rf_rdata got %h %h %h %h want 11 22 33 44", obs_rd[0], obs_rd[1], obs_rd[2], obs_rd[3]); else n_pass++;
        n_checks++; if ({gap_bad, stable_bad} !== 64'd0) $display("FAIL rf_gap got %0d/%0d want 0/0", gap_bad, stable_bad); else n_pass++;
        n_checks++; if (first_rv_cyc - accept_cyc !== 3) $display("FAIL rf_latency got %0d want 3", first_rv_cyc - accept_cyc); else n_pass++;
        n_checks++; if ({done_cnt, 31'd0, err_at_done} !== {32'd1, 32'd0}) $display("FAIL rf_done got %0d err %b want 1 err 0", done_cnt, err_at_done); else n_pass++;
    endtask

    task automatic test_read_incr_stall();
        clear_knobs();
        rresp[0] = 32'hA0A0_0001; rresp[1] = 32'hB0B0_0002; rresp[2] = 32'hC0C0_0003;
        stall_beat = 1; stall_cyc = 5;
        run_burst(1'b1 ^ 1'b1, REG_CFGR, 4'd2, 1'b1, 40);
        n_checks++; if ({obs_addr[0], obs_addr[1], obs_addr[2]} !== 24'h1C2024)
            $display("FAIL ri_addr got %h %h %h want 1c 20 24", obs_addr[0], obs_addr[1], obs_addr[2]); else n_pass++;
        n_checks++; if ({obs_rd[0], obs_rd[1], obs_rd[2]} !== {32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003})
            $display("FAIL ri_rdata got %h %h %h want a0a00001 b0b00002 c0c00003", obs_rd[0], obs_rd[1], obs_rd[2]); else n_pass++;
        n_checks++; if (stall_bad !== 0) $display("FAIL ri_stall got %0d want 0", stall_bad); else n_pass++;
        n_checks++; if (done_cyc !== 15) $display("FAIL ri_done_cyc got %0d want 15", done_cyc); else n_pass++;
    endtask

    task automatic test_wait_states();
        clear_knobs();
        wbeats[0] = 32'hCAFE_F00D; wait_cyc[0] = 3;
        run_burst(1'b1, REG_DR, 4'd0, 1'b0, 20);
        n_checks++; if (obs_acc[0] !== 4) $display("FAIL ws_access got %0d want 4", obs_acc[0]); else n_pass++;
        n_checks++; if (stable_bad !== 0) $display("FAIL ws_stable got %0d want 0", stable_bad); else n_pass++;
        n_checks++; if ({done_cnt, 31'd0, err_at_done} !== {32'd1, 32'd0}) $display("FAIL ws_done got %0d err %b want 1 err 0", done_cnt, err_at_done); else n_pass++;
        n_checks++; if (obs_wd[0] !== 32'hCAFE_F00D) $display("FAIL ws_pwdata got %h want cafef00d", obs_wd[0]); else n_pass++;
        clear_knobs();
        rresp[0] = 32'h5A5A_0001; wait_cyc[0] = 2;
        run_burst(1'b0, REG_DREG, 4'd0, 1'b0, 20);
        n_checks++; if (obs_acc[0] !== 3) $display("FAIL ws_rd_access got %0d want 3", obs_acc[0]); else n_pass++;
        n_checks++; if (obs_rd[0] !== 32'h5A5A_0001) $display("FAIL ws_rd_data got %h want 5a5a0001", obs_rd[0]); else n_pass++;
        n_checks++; if (err_at_done !== 1'b0) $display("FAIL ws_rd_err got %b want 0", err_at_done); else n_pass++;
    endtask

    task automatic test_timeout();
        clear_knobs();
        wait_cyc[0] = 1000;
        run_burst(1'b0, REG_HINT, 4'd2, 1'b1, 60);
        n_checks++; if (obs_acc[0] !== 16) $display("FAIL to_access got %0d want 16", obs_acc[0]); else n_pass++;
        n_checks++; if ({n_setup, n_xfer, n_rd} !== {32'd1, 32'd1, 32'd0})
            $display("FAIL to_beats got setup %0d xfer %0d rd %0d want 1 1 0", n_setup, n_xfer, n_rd); else n_pass++;
        n_checks++; if ({done_cnt, 31'd0, err_at_done} !== {32'd1, 32'd1}) $display("FAIL to_done got %0d err %b want 1 err 1", done_cnt, err_at_done); else n_pass++;
    endtask

    task automatic test_slverr();
        clear_knobs();
        for (int i = 0; i < 4; i++) wbeats[i] = 32'h5000 + i;
        err_beat = 1;
        run_burst(1'b1, REG_CR1, 4'd3, 1'b1, 40);
        n_checks++; if ({n_setup, n_xfer, n_wd} !== {32'd2, 32'd2, 32'd2})
            $display("FAIL se_beats got setup %0d xfer %0d wd %0d want 2 2 2", n_setup, n_xfer, n_wd); else n_pass++;
        n_checks++; if ({obs_addr[1], obs_wd[1]} !== {8'h04, 32'h5001}) $display("FAIL se_beat2 got %h %h want 04 00005001", obs_addr[1], obs_wd[1]); else n_pass++;
        n_checks++; if ({done_cnt, 31'd0, err_at_done} !== {32'd1, 32'd1}) $display("FAIL se_done got %0d err %b want 1 err 1", done_cnt, err_at_done); else n_pass++;
        clear_knobs();
        rresp[0] = 32'hBAD0_0001; err_beat = 0;
        run_burst(1'b0, REG_SR, 4'd1, 1'b0, 30);
        n_checks++; if ({n_xfer, n_rd} !== {32'd1, 32'd1}) $display("FAIL se_rd_beats got xfer %0d rd %0d want 1 1", n_xfer, n_rd); else n_pass++;
        n_checks++; if (obs_rd[0] !== 32'hBAD0_0001) $display("FAIL se_rd_data got %h want bad00001", obs_rd[0]); else n_pass++;
        n_checks++; if (err_at_done !== 1'b1) $display("FAIL se_rd_err got %b want 1", err_at_done); else n_pass++;
    endtask

    task automatic test_len_max();
        clear_knobs();
        for (int i = 0; i < 16; i++) wbeats[i] = 32'h100 + i;
        run_burst(1'b1, 8'hF0, 4'hF, 1'b1, 90);
        n_checks++; if (n_xfer !== 16) $display("FAIL lm_xfers got %0d want 16", n_xfer); else n_pass++;
        n_checks++; if ({obs_addr[3], obs_addr[4], obs_addr[15]} !== 24'hFC002C)
            $display("FAIL lm_wrap got %h %h %h want fc 00 2c", obs_addr[3], obs_addr[4], obs_addr[15]); else n_pass++;
        n_checks++; if (obs_wd[15] !== 32'h10F) $display("FAIL lm_last_data got %h want 10f", obs_wd[15]); else n_pass++;
        n_checks++; if ({done_cnt, 31'd0, err_at_done} !== {32'd1, 32'd0}) $display("FAIL lm_done got %0d err %b want 1 err 0", done_cnt, err_at_done); else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = REG_CR2; cmd_len = 4'd0; cmd_incr = 1'b0;
        rdata_ready = 1'b1; pslverr = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        pready = 1'b1; prdata = 32'h77;
        @(negedge pclk);
        pready = 1'b0;
        n_checks++; if ({rdata_valid, rdata} !== {1'b1, 32'h77}) $display("FAIL bb_rdata got %b %h want 1 00000077", rdata_valid, rdata); else n_pass++;
        @(negedge pclk);
        n_checks++; if ({done, cmd_ready, busy} !== 3'b110) $display("FAIL bb_done got %b want 110", {done, cmd_ready, busy}); else n_pass++;
        cmd_valid = 1'b1; cmd_addr = REG_SR;
        @(negedge pclk);
        cmd_valid = 1'b0;
        n_checks++; if ({psel, penable, busy, done, paddr} !== {4'b1010, 8'h08})
            $display("FAIL bb_second got %b %h want 1010 08", {psel, penable, busy, done}, paddr); else n_pass++;
        pready = 1'b1;
        repeat (4) @(negedge pclk);
        pready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int dones;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = REG_DR; cmd_len = 4'd3; cmd_incr = 1'b0;
        pready = 1'b0; pslverr = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        n_checks++; if ({psel, penable} !== 2'b11) $display("FAIL rm_in_access got %b want 11", {psel, penable}); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({psel, penable, pwrite, cmd_ready, wdata_ready, rdata_valid, done, err, busy} !== 9'b0)
            $display("FAIL rm_ctrl got %b want 000000000", {psel, penable, pwrite, cmd_ready, wdata_ready, rdata_valid, done, err, busy}); else n_pass++;
        n_checks++; if ({paddr, pwdata, rdata} !== 72'h0) $display("FAIL rm_data got %h want 0", {paddr, pwdata, rdata}); else n_pass++;
        @(negedge pclk);
        rst_n = 1'b1;
        dones = 0;
        repeat (6) begin
            @(negedge pclk);
            if (done) dones++;
        end
        n_checks++; if (dones !== 0) $display("FAIL rm_no_done got %0d want 0", dones); else n_pass++;
        n_checks++; if ({cmd_ready, busy} !== 2'b10) $display("FAIL rm_idle got %b want 10", {cmd_ready, busy}); else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_incr = 1'b0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b1;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        clear_knobs();
        test_reset();
        test_single_write();
        test_read_fixed();
        test_read_incr_stall();
        test_wait_states();
        test_timeout();
        test_slverr();
        test_len_max();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
